// File: rtl/clk_div_pkg.sv
// Shared defaults and types for the clk_div controller.
// Channel count, divisor width, channel config record.
package clk_div_pkg;
  localparam int NCH_DEF = 4;
  localparam int CW_DEF  = 17;
  localparam int CHW     = $clog2(NCH_DEF);

  typedef struct packed {
    logic              en;
    logic [CW_DEF-1:0] div;
  } chan_cfg_t;
endpackage

// File: rtl/clk_div_if.sv
// Config request port: valid/ready handshake carrying ch, div, en.
// master = requester, slave = clk_div_ctrl.
interface clk_div_if import clk_div_pkg::*; #(
  parameter int NCH = NCH_DEF,
  parameter int CW  = CW_DEF
);
  logic                   valid;
  logic                   ready;
  logic [$clog2(NCH)-1:0] ch;
  logic [CW-1:0]          div;
  logic                   en;

  modport master (
    output valid, ch, div, en,
    input  ready
  );
  modport slave (
    input  valid, ch, div, en,
    output ready
  );
endinterface

// File: rtl/clk_div_chan.sv
// One divider channel: counter, active/shadow cfg, pending, apply.
// Ports: clk, rst, wr/wr_en/wr_div in; clk_out, tick, run, pend out.
module clk_div_chan #(
  parameter int CW = 17
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          wr,
  input  logic          wr_en,
  input  logic [CW-1:0] wr_div,
  output logic          clk_out,
  output logic          tick,
  output logic          run,
  output logic          pend
);
  logic [CW-1:0] cnt_q, cnt_d;
  logic [CW-1:0] div_q, div_d;
  logic [CW-1:0] sdiv_q, sdiv_d;
  logic          en_q, en_d;
  logic          sen_q, sen_d;
  logic          pend_q, pend_d;
  logic          clk_q, clk_d;
  logic          tick_q, tick_d;
  logic          term;

  assign term = en_q && (cnt_q == div_q);

  always_comb begin
    cnt_d  = cnt_q;
    div_d  = div_q;
    sdiv_d = sdiv_q;
    en_d   = en_q;
    sen_d  = sen_q;
    pend_d = pend_q;
    clk_d  = clk_q;
    tick_d = 1'b0;
    // wr never coincides with pend_q: ready is low while pending
    if (wr) begin
      sdiv_d = wr_div;
      sen_d  = wr_en;
      pend_d = 1'b1;
    end
    unique case (1'b1)
      !en_q: begin
        cnt_d = '0;
        clk_d = 1'b0;
        if (pend_q) begin
          en_d   = sen_q;
          div_d  = sdiv_q;
          pend_d = 1'b0;
        end
      end
      term: begin
        cnt_d  = '0;
        clk_d  = ~clk_q;
        tick_d = 1'b1;
        if (pend_q) begin
          en_d   = sen_q;
          div_d  = sdiv_q;
          pend_d = 1'b0;
          // stopping: only a high clock gets its final fall
          if (!sen_q) begin
            clk_d  = 1'b0;
            tick_d = clk_q;
          end
        end
      end
      default: cnt_d = cnt_q + 1'b1;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q  <= '0;
      div_q  <= '0;
      sdiv_q <= '0;
      en_q   <= 1'b0;
      sen_q  <= 1'b0;
      pend_q <= 1'b0;
      clk_q  <= 1'b0;
      tick_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      div_q  <= div_d;
      sdiv_q <= sdiv_d;
      en_q   <= en_d;
      sen_q  <= sen_d;
      pend_q <= pend_d;
      clk_q  <= clk_d;
      tick_q <= tick_d;
    end
  end

  assign clk_out = clk_q;
  assign tick    = tick_q;
  assign run     = en_q;
  assign pend    = pend_q;
endmodule

// File: rtl/clk_div_ctrl.sv
// Multi-channel clock divider: cfg port, NCH clk_div_chan instances.
// Ports: clk_in, rst, cfg (slave), clk_out, tick; run/pend if CLKDIV_STATUS_EN.
module clk_div_ctrl import clk_div_pkg::*; #(
  parameter int NCH = NCH_DEF,
  parameter int CW  = CW_DEF
) (
  input  logic           clk_in,
  input  logic           rst,
  clk_div_if.slave       cfg,
  output logic [NCH-1:0] clk_out,
  output logic [NCH-1:0] tick
`ifdef CLKDIV_STATUS_EN
  ,
  output logic [NCH-1:0] run,
  output logic [NCH-1:0] pend
`endif
);
  localparam int CHB = $clog2(NCH);

  logic [NCH-1:0] pend_w;
  logic [NCH-1:0] run_w;
  logic [NCH-1:0] wr;
  logic           hit;

  // out-of-range channels are accepted and dropped
  assign hit = int'(cfg.ch) < NCH;
  assign cfg.ready = hit ? ~pend_w[cfg.ch] : 1'b1;

  for (genvar i = 0; i < NCH; i++) begin : g_ch
    assign wr[i] = cfg.valid & cfg.ready
                 & (cfg.ch == CHB'(i));
    clk_div_chan #(.CW(CW)) u_chan (
      .clk     (clk_in),
      .rst     (rst),
      .wr      (wr[i]),
      .wr_en   (cfg.en),
      .wr_div  (cfg.div),
      .clk_out (clk_out[i]),
      .tick    (tick[i]),
      .run     (run_w[i]),
      .pend    (pend_w[i])
    );
  end

`ifdef CLKDIV_STATUS_EN
  assign run  = run_w;
  assign pend = pend_w;
`else
  logic unused_run;
  assign unused_run = ^run_w;
`endif
endmodule

// File: tb/tb_clk_div_ctrl.sv
// Testbench for clk_div_ctrl: table, directed, random vs model.
// Model derives toggles from segment start and (div+1) period.
module tb_clk_div_ctrl;
  localparam int NCH = 4;
  localparam int CW  = 17;

  logic clk_in = 1'b0;
  logic rst = 1'b0;
  logic [NCH-1:0] clk_out, tick;
`ifdef CLKDIV_STATUS_EN
  logic [NCH-1:0] run, pend;
`endif

  clk_div_if #(.NCH(NCH), .CW(CW)) cfg_if ();

  clk_div_ctrl #(.NCH(NCH), .CW(CW)) dut (
    .clk_in  (clk_in),
    .rst     (rst),
    .cfg     (cfg_if),
    .clk_out (clk_out),
    .tick    (tick)
`ifdef CLKDIV_STATUS_EN
    ,
    .run     (run),
    .pend    (pend)
`endif
  );

  always #5 clk_in = ~clk_in;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm,
                     input longint act,
                     input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d",
               nm, act, exp);
    end
  endtask

  // reference model
  longint         cyc = 0;
  bit [NCH-1:0]   m_en, m_sen, m_pend;
  bit [NCH-1:0]   m_clk, m_tick;
  int             m_div [NCH];
  int             m_sdiv[NCH];
  longint         m_seg [NCH];
  bit             m_acc;

  always @(posedge clk_in or posedge rst) begin
    if (rst) begin
      m_en = '0; m_sen = '0; m_pend = '0;
      m_clk = '0; m_tick = '0; m_acc = 0;
      for (int c = 0; c < NCH; c++) begin
        m_div[c] = 0; m_sdiv[c] = 0; m_seg[c] = 0;
      end
    end else begin
      bit acc;
      cyc++;
      acc = cfg_if.valid && !m_pend[cfg_if.ch];
      for (int c = 0; c < NCH; c++) begin
        bit tk;
        tk = 0;
        if (m_en[c]) begin
          if ((cyc - m_seg[c]) % (m_div[c] + 1) == 0) begin
            if (m_pend[c] && !m_sen[c]) begin
              tk = m_clk[c];
              m_clk[c] = 0;
              m_en[c] = 0;
            end else begin
              m_clk[c] = ~m_clk[c];
              tk = 1;
            end
            if (m_pend[c]) begin
              m_div[c] = m_sdiv[c];
              m_seg[c] = cyc;
              m_pend[c] = 0;
            end
          end
        end else if (m_pend[c]) begin
          m_en[c] = m_sen[c];
          m_div[c] = m_sdiv[c];
          m_seg[c] = cyc;
          m_clk[c] = 0;
          m_pend[c] = 0;
        end
        m_tick[c] = tk;
      end
      if (acc) begin
        m_sdiv[cfg_if.ch] = int'(cfg_if.div);
        m_sen[cfg_if.ch] = cfg_if.en;
        m_pend[cfg_if.ch] = 1;
      end
      m_acc = acc;
    end
  end

  // continuous comparison on the falling edge
  always @(negedge clk_in) begin
    chk("cont clk_out", longint'(clk_out),
        longint'(m_clk));
    chk("cont tick", longint'(tick),
        longint'(m_tick));
    chk("cont cfg_ready", longint'(cfg_if.ready),
        longint'(!m_pend[cfg_if.ch]));
`ifdef CLKDIV_STATUS_EN
    chk("cont pend", longint'(pend),
        longint'(m_pend));
    chk("cont run", longint'(run),
        longint'(m_en));
`endif
  end

  task automatic step();
    @(negedge clk_in);
    #1;
  endtask

  task automatic wr(input int ch, input int d,
                    input bit en);
    int n;
    cfg_if.valid = 1'b1;
    cfg_if.ch = 2'(ch);
    cfg_if.div = CW'(d);
    cfg_if.en = en;
    n = 0;
    do begin
      step();
      n++;
    end while (!m_acc && n < 500);
    if (!m_acc) chk("wr timeout", 0, 1);
    cfg_if.valid = 1'b0;
  endtask

  task automatic wait_idle(input int ch);
    int n;
    n = 0;
    while (m_pend[ch] && n < 500) begin
      step();
      n++;
    end
    if (m_pend[ch]) chk("idle timeout", 0, 1);
  endtask

  typedef struct {
    int ch;
    int d;
    int w;
    bit eclk;
    bit etick;
  } vec_t;
  vec_t tbl[7];

  initial begin
    int n, ticks, falls;
    bit prev, seen0;

    tbl[0] = '{2, 3, 5, 1, 1};
    tbl[1] = '{2, 3, 6, 1, 0};
    tbl[2] = '{3, 2, 10, 1, 1};
    tbl[3] = '{3, 2, 8, 0, 0};
    tbl[4] = '{1, 0, 3, 0, 1};
    tbl[5] = '{2, 5, 1, 0, 0};
    tbl[6] = '{3, 1, 4, 1, 0};

    cfg_if.valid = 1'b0;
    cfg_if.ch = '0;
    cfg_if.div = '0;
    cfg_if.en = 1'b0;
    #1 rst = 1'b1;
    #2;
    chk("rst clk_out", longint'(clk_out), 0);
    chk("rst tick", longint'(tick), 0);
    chk("rst ready", longint'(cfg_if.ready), 1);
    repeat (3) @(negedge clk_in);
    rst = 1'b0;
    step();

    // table: start a stopped channel, sample after w edges
    foreach (tbl[i]) begin
      wr(tbl[i].ch, tbl[i].d, 1'b1);
      repeat (tbl[i].w) step();
      chk($sformatf("tbl%0d clk", i),
          longint'(clk_out[tbl[i].ch]),
          longint'(tbl[i].eclk));
      chk($sformatf("tbl%0d tick", i),
          longint'(tick[tbl[i].ch]),
          longint'(tbl[i].etick));
      wr(tbl[i].ch, tbl[i].d, 1'b0);
      wait_idle(tbl[i].ch);
      step();
    end

    // start: ch0 div=49
    wr(0, 49, 1'b1);
    n = 0;
    do begin step(); n++; end
    while (!clk_out[0] && n < 300);
    chk("start first rise", n - 1, 50);
    n = 0; seen0 = 0;
    do begin
      step(); n++;
      if (!clk_out[0]) seen0 = 1;
    end while (!(seen0 && clk_out[0]) && n < 300);
    chk("start period", n, 100);
    ticks = 0;
    repeat (100) begin
      step();
      ticks += int'(tick[0]);
    end
    chk("start ticks/period", ticks, 2);

    // div=0 on ch1
    wr(1, 0, 1'b1);
    step();
    prev = clk_out[1];
    for (int i = 0; i < 6; i++) begin
      step();
      chk("div0 tick", longint'(tick[1]), 1);
      chk("div0 toggle", longint'(clk_out[1]),
          longint'(!prev));
      prev = clk_out[1];
    end

    // retune ch0 at cnt=10
    n = 0;
    while ((cyc - m_seg[0]) % 50 != 10 && n < 200) begin
      step(); n++;
    end
    wr(0, 9, 1'b1);
    n = 0;
    while (!cfg_if.ready && n < 200) begin
      step(); n++;
    end
    chk("retune ready low", n, 39);
    prev = clk_out[0];
    n = 0;
    do begin step(); n++; end
    while (clk_out[0] == prev && n < 200);
    chk("retune half-period", n, 10);

    // stall on pending ch0, ch2 goes through
    wait_idle(0);
    wr(0, 9, 1'b1);
    cfg_if.valid = 1'b1;
    cfg_if.ch = 2'd0;
    #1;
    chk("stall ch0 ready", longint'(cfg_if.ready), 0);
    cfg_if.ch = 2'd2;
    cfg_if.div = CW'(7);
    cfg_if.en = 1'b1;
    #1;
    chk("stall ch2 ready", longint'(cfg_if.ready), 1);
    step();
    chk("stall ch2 taken", longint'(cfg_if.ready), 0);
    cfg_if.valid = 1'b0;

    // stop ch0 while high
    wait_idle(0);
    n = 0;
    prev = clk_out[0];
    step();
    while (!(!prev && clk_out[0]) && n < 100) begin
      prev = clk_out[0];
      step(); n++;
    end
    wr(0, 9, 1'b0);
    falls = 0; ticks = 0;
    prev = clk_out[0];
    repeat (40) begin
      if (prev && !clk_out[0]) falls++;
      ticks += int'(tick[0]);
      prev = clk_out[0];
      step();
    end
    chk("stop falls", falls, 1);
    chk("stop ticks", ticks, 1);
    chk("stop clk", longint'(clk_out[0]), 0);
    chk("stop tick", longint'(tick[0]), 0);

    // random traffic
    for (int i = 0; i < 40; i++) begin
      wr(int'($urandom_range(0, NCH - 1)),
         int'($urandom_range(0, 15)),
         ($urandom_range(0, 3) != 0));
      repeat ($urandom_range(0, 30)) step();
    end

    // async reset mid-run
    wr(0, 3, 1'b1);
    repeat (10) step();
    @(posedge clk_in);
    #2 rst = 1'b1;
    #1;
    chk("mid rst clk_out", longint'(clk_out), 0);
    chk("mid rst tick", longint'(tick), 0);
    chk("mid rst ready", longint'(cfg_if.ready), 1);
    repeat (2) @(negedge clk_in);
    rst = 1'b0;
    repeat (20) step();
    chk("post rst clk_out", longint'(clk_out), 0);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end
endmodule
